seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles per digit scan step (minimum 2).
REQ-002 Parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (minimum 2).
REQ-003 clk  in  1  system clock, 100 MHz; all logic on rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 enable  in  1  1 = display driven; 0 = display blanked, editing still active.
REQ-006 btn_left, btn_right, btn_up, btn_down  in  1 each  debounced button levels, active-high.
REQ-007 load  in  1  single-cycle strobe; replaces all digit values.
REQ-008 load_data  in  16  four hex digits; [3:0] is digit 0 (rightmost).
REQ-009 sel  out  4  digit select, active-low, one-cold; bit 0 = rightmost digit.
REQ-010 seg  out  8  segments, active-low; [6:0] = g..a, [7] = decimal point.
REQ-011 digits  out  16  current digit values, same packing as load_data.
REQ-012 cursor  out  2  index of the edit-selected digit.

Function
REQ-013 Rising edge per button = btn high this cycle, low the previous cycle; one edge = one action.
REQ-014 Left edge: cursor+1 mod 4 (3->0). Right edge: cursor-1 mod 4 (0->3). Both edges in the same cycle: cursor unchanged.
REQ-015 Up edge: digit[cursor]+1 mod 16 (F->0). Down edge: digit[cursor]-1 mod 16 (0->F). Both in the same cycle: unchanged.
REQ-016 Cursor and up/down edges in the same cycle: the digit edit uses the pre-move cursor value.
REQ-017 load=1: digits<=load_data; overrides any up/down edit in the same cycle; cursor unaffected.
REQ-018 digits/cursor update on the clock edge after the button edge is detected: 1 cycle after btn rises.
REQ-019 Scan counter counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and scan index advances 0->1->2->3->0.
REQ-020 Blink counter counts 0..BLINK_DIV-1; at terminal count it wraps and blink phase toggles.
REQ-021 sel and seg registered; they reflect scan index and digit values with 1 cycle latency.
REQ-022 enable=1: sel = ~(1<<idx); seg[6:0] = hex pattern of digit[idx] (0-F, standard 7-seg).
REQ-023 enable=1, idx==cursor, blink phase 1: seg[6:0]=7'h7F (blanked); seg[7]=0 on the cursor digit in both phases.
REQ-024 seg[7]=1 on all non-cursor digits.
REQ-025 enable=0: sel=4'hF, seg=8'hFF; scan and blink counters continue running.
REQ-026 Digit changes show on the next scan of that digit; no glitch between sel and seg (both from the same register stage).

Reset
REQ-027 rst_n=0 at a clk edge: digits=16'h0000, cursor=0, scan index=0, scan and blink counters=0, blink phase=0, sel=4'hF, seg=8'hFF.
REQ-028 Reset clears the button history registers to 0; a button held through reset release produces exactly one edge.
REQ-029 Reset mid-blink or mid-scan discards all progress; no partial state survives.

Structure
REQ-030 Shared package holds the 16-entry hex-to-segment table and the digit-count constant (4).
REQ-031 Sub-module seg_hex_decode: pure combinational 4-bit to 7-bit active-low decoder; instantiated once on the scan-mux output.

Verification (SCAN_DIV=4, BLINK_DIV=16)
REQ-032 Reset then enable=1, idle 16 cycles -> sel cycles E,D,B,7 every 4 cycles; seg=8'h40 on cursor digit 0 during blink phase 0, 8'hC0 on the others.
REQ-033 Cursor at 0, four btn_up pulses, then btn_down held 3 cycles -> digits=16'h0004, then 16'h0003 (single step only).
REQ-034 btn_right once from cursor 0 -> cursor=3; btn_up -> digits=16'h1000; btn_down at 16'h0000 -> digit wraps to F.
REQ-035 load=1 with load_data=16'hBEEF while btn_up edges in the same cycle -> digits=16'hBEEF, cursor unchanged.
REQ-036 Blink phase 1 at the cursor digit -> seg=8'h7F; enable=0 at any time -> sel=4'hF, seg=8'hFF on the next cycle.
REQ-037 rst_n=0 for 1 cycle mid-scan with btn_left held -> all state reset; after release, exactly one cursor increment (cursor=1).

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared constants and hex-to-segment table for the digit scanner
package seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low segment patterns, bit order g..a, indexed by hex value
    localparam logic [6:0] HEX_SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex digit to active-low 7-segment decoder
module seg_hex_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_LUT[i_hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit multiplexed 7-segment scanner with button-driven digit editing
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        load,
    input  logic [15:0] load_data,
    output logic [3:0]  sel,
    output logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [1:0]  cursor
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [3:0]                  r_btn_prev;
    logic [NUM_DIGITS-1:0][3:0]  r_digits;
    logic [1:0]                  r_cursor;
    logic [SCAN_W-1:0]           r_scan_cnt;
    logic [1:0]                  r_scan_idx;
    logic [BLINK_W-1:0]          r_blink_cnt;
    logic                        r_blink;
    logic [3:0]                  r_sel;
    logic [7:0]                  r_seg;

    logic [3:0] w_btn;
    logic [3:0] w_edge;
    logic       w_left;
    logic       w_right;
    logic       w_inc;
    logic       w_dec;
    logic [1:0] w_cursor_nxt;
    logic       w_scan_tc;
    logic       w_blink_tc;
    logic [3:0] w_scan_digit;
    logic [6:0] w_hex_seg;

    assign w_btn  = {btn_down, btn_up, btn_right, btn_left};
    assign w_edge = w_btn & ~r_btn_prev;

    // Opposing edges in the same cycle cancel out
    assign w_left  = w_edge[0] & ~w_edge[1];
    assign w_right = w_edge[1] & ~w_edge[0];
    assign w_inc   = w_edge[2] & ~w_edge[3];
    assign w_dec   = w_edge[3] & ~w_edge[2];

    always_comb begin
        w_cursor_nxt = r_cursor;
        if (w_left) begin
            w_cursor_nxt = r_cursor + 2'd1;
        end else if (w_right) begin
            w_cursor_nxt = r_cursor - 2'd1;
        end
    end

    assign w_scan_tc  = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign w_blink_tc = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btn_prev <= '0;
            r_digits   <= '0;
            r_cursor   <= '0;
        end else begin
            r_btn_prev <= w_btn;
            r_cursor   <= w_cursor_nxt;
            // Edits address the pre-move cursor; a load wins over any edit
            if (load) begin
                r_digits <= load_data;
            end else if (w_inc) begin
                r_digits[r_cursor] <= r_digits[r_cursor] + 4'd1;
            end else if (w_dec) begin
                r_digits[r_cursor] <= r_digits[r_cursor] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_scan_idx  <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            if (w_scan_tc) begin
                r_scan_cnt <= '0;
                r_scan_idx <= r_scan_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end
            if (w_blink_tc) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign w_scan_digit = r_digits[r_scan_idx];

    seg_hex_decode u_hex_decode (
        .i_hex (w_scan_digit),
        .o_seg (w_hex_seg)
    );

    // sel and seg share one register stage so they always switch together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel <= 4'hF;
            r_seg <= 8'hFF;
        end else if (!enable) begin
            r_sel <= 4'hF;
            r_seg <= 8'hFF;
        end else begin
            r_sel <= ~(4'b0001 << r_scan_idx);
            if (r_scan_idx == r_cursor) begin
                r_seg <= {1'b0, (r_blink ? 7'h7F : w_hex_seg)};
            end else begin
                r_seg <= {1'b1, w_hex_seg};
            end
        end
    end

    assign sel    = r_sel;
    assign seg    = r_seg;
    assign digits = r_digits;
    assign cursor = r_cursor;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        btn_left, btn_right, btn_up, btn_down;
    logic        load;
    logic [15:0] load_data;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [1:0]  cursor;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        l, r, u, d, ld;
        logic [15:0] ldat;
        logic [15:0] edig;
        logic [1:0]  ecur;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .load      (load),
        .load_data (load_data),
        .sel       (sel),
        .seg       (seg),
        .digits    (digits),
        .cursor    (cursor)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // k = number of clock edges since reset release; outputs after edge k reflect state before it
    task automatic check_disp(input int k, input logic en, input logic [15:0] dg, input logic [1:0] cur);
        int         idx;
        logic       ph;
        logic [3:0] onehot;
        logic [3:0] d;
        logic [3:0] esel;
        logic [7:0] eseg;
        idx    = ((k - 1) / SCAN_DIV) % 4;
        ph     = logic'(((k - 1) / BLINK_DIV) % 2);
        onehot = 4'b0001 << idx;
        d      = dg[idx*4 +: 4];
        if (!en) begin
            esel = 4'hF;
            eseg = 8'hFF;
        end else begin
            esel = ~onehot;
            if (idx == int'(cur)) eseg = {1'b0, (ph ? 7'h7F : hex7(d))};
            else                  eseg = {1'b1, hex7(d)};
        end
        chk($sformatf("sel_k%0d", k), {28'h0, sel}, {28'h0, esel});
        chk($sformatf("seg_k%0d", k), {24'h0, seg}, {24'h0, eseg});
    endtask

    task automatic add(input logic l, r, u, d, ld, input logic [15:0] ldat,
                       input logic [15:0] edig, input logic [1:0] ecur);
        vec_t v;
        v.l = l; v.r = r; v.u = u; v.d = d; v.ld = ld;
        v.ldat = ldat; v.edig = edig; v.ecur = ecur;
        vecs.push_back(v);
    endtask

    initial begin
        //   l  r  u  d  ld  ldat      digits    cur
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0001, 2'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0001, 2'd0);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0002, 2'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0002, 2'd0);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0003, 2'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0003, 2'd0);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0004, 2'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0004, 2'd0);
        add(0, 0, 0, 1, 0, 16'h0000, 16'h0003, 2'd0);
        add(0, 0, 0, 1, 0, 16'h0000, 16'h0003, 2'd0);
        add(0, 0, 0, 1, 0, 16'h0000, 16'h0003, 2'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0003, 2'd0);
        add(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 2'd0);
        add(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 2'd3);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'd3);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h1000, 2'd3);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h1000, 2'd3);
        add(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 2'd3);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'd3);
        add(0, 0, 0, 1, 0, 16'h0000, 16'hF000, 2'd3);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hF000, 2'd3);
        add(1, 0, 0, 0, 0, 16'h0000, 16'hF000, 2'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hF000, 2'd0);
        add(1, 1, 0, 0, 0, 16'h0000, 16'hF000, 2'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hF000, 2'd0);
        add(0, 0, 1, 1, 0, 16'h0000, 16'hF000, 2'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hF000, 2'd0);
        add(1, 0, 1, 0, 0, 16'h0000, 16'hF001, 2'd1);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hF001, 2'd1);
        add(0, 1, 0, 1, 0, 16'h0000, 16'hF0F1, 2'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hF0F1, 2'd0);
        add(0, 0, 1, 0, 1, 16'hBEEF, 16'hBEEF, 2'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hBEEF, 2'd0);
        add(0, 0, 0, 0, 1, 16'h000F, 16'h000F, 2'd0);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 2'd0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'd0);
        add(1, 0, 0, 0, 1, 16'h1234, 16'h1234, 2'd1);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h1234, 2'd1);

        rst_n = 1'b0; enable = 1'b1; load = 1'b0; load_data = 16'h0;
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        repeat (3) tick();
        chk("rst_sel", {28'h0, sel}, 32'hF);
        chk("rst_seg", {24'h0, seg}, 32'hFF);
        chk("rst_digits", {16'h0, digits}, 32'h0);
        chk("rst_cursor", {30'h0, cursor}, 32'h0);

        // Scan/blink from reset, with a blanking window mid-run
        rst_n = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            enable = (k >= 41 && k <= 45) ? 1'b0 : 1'b1;
            tick();
            check_disp(k, enable, 16'h0000, 2'd0);
        end
        enable = 1'b1;

        foreach (vecs[i]) begin
            btn_left  = vecs[i].l;
            btn_right = vecs[i].r;
            btn_up    = vecs[i].u;
            btn_down  = vecs[i].d;
            load      = vecs[i].ld;
            load_data = vecs[i].ldat;
            tick();
            chk($sformatf("vec%0d_digits", i), {16'h0, digits}, {16'h0, vecs[i].edig});
            chk($sformatf("vec%0d_cursor", i), {30'h0, cursor}, {30'h0, vecs[i].ecur});
        end
        load = 1'b0;

        // One-cycle reset mid-scan with btn_left held through release
        btn_left = 1'b1;
        rst_n    = 1'b0;
        tick();
        chk("mrst_sel", {28'h0, sel}, 32'hF);
        chk("mrst_seg", {24'h0, seg}, 32'hFF);
        chk("mrst_digits", {16'h0, digits}, 32'h0);
        chk("mrst_cursor", {30'h0, cursor}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("held_cursor_k1", {30'h0, cursor}, 32'h1);
        check_disp(1, 1'b1, 16'h0000, 2'd0);
        tick();
        chk("held_cursor_k2", {30'h0, cursor}, 32'h1);
        check_disp(2, 1'b1, 16'h0000, 2'd1);
        btn_left  = 1'b0;
        load      = 1'b1;
        load_data = 16'hA5C3;
        tick();
        load = 1'b0;
        chk("load_digits_k3", {16'h0, digits}, 32'hA5C3);
        check_disp(3, 1'b1, 16'h0000, 2'd1);
        for (int k = 4; k <= 40; k++) begin
            tick();
            check_disp(k, 1'b1, 16'hA5C3, 2'd1);
        end
        chk("final_cursor", {30'h0, cursor}, 32'h1);
        chk("final_digits", {16'h0, digits}, 32'hA5C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
